mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single physical memory port (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata, mem_rdata/mem_resp) between an instruction-fetch requester (I) and a data load/store requester (D).
- Sits between the CPU's split I/D memory interfaces and the memory.
- Grants one request at a time, latches its command, holds it stable until mem_resp, then routes the response back to the owner.
- Data has priority; a streak counter bounds instruction starvation.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports. Byte enable is DATA_WIDTH/8 bits.
- MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced. Legal values are 1 and above.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  instruction read request; held until i_resp.
- i_address  in  ADDR_WIDTH  instruction address.
- i_rdata  out  DATA_WIDTH  instruction read data.
- i_resp  out  1  one-cycle completion pulse to I.
- d_read  in  1  data read request; held until d_resp.
- d_write  in  1  data write request; held until d_resp.
- d_byte_enable  in  DATA_WIDTH/8  data byte enables.
- d_address  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  data write data.
- d_rdata  out  DATA_WIDTH  data read data.
- d_resp  out  1  one-cycle completion pulse to D.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_byte_enable  out  DATA_WIDTH/8  memory byte enables.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_resp  in  1  memory completion pulse.

Behaviour:
- States are IDLE, SERVE_I and SERVE_D. All mem_* outputs are registered.
- Reset (rst=0), asynchronous:
  - state=IDLE, streak=0.
  - mem_read=0, mem_write=0, mem_byte_enable=0, mem_address=0, mem_wdata=0.
  - i_resp=0, d_resp=0. i_rdata and d_rdata follow mem_rdata.
- IDLE arbitration, evaluated each cycle:
  - Let dreq = d_read or d_write.
  - If dreq and (not i_read or streak < MAX_D_STREAK): grant D, go to SERVE_D.
  - Else if i_read: grant I, go to SERVE_I.
  - Else stay in IDLE.
- Streak counter update at grant:
  - D grant while i_read=1: streak += 1, saturating at MAX_D_STREAK.
  - D grant while i_read=0: streak = 0.
  - I grant: streak = 0.
- Command latch at grant, on the same edge as the state change:
  - I grant: mem_read=1, mem_write=0, mem_byte_enable=all ones, mem_address=i_address, mem_wdata=0.
  - D grant: mem_address=d_address, mem_wdata=d_wdata, mem_byte_enable=d_byte_enable.
  - D grant with d_write=1: mem_write=1, mem_read=0. Write wins if d_read and d_write are both 1 (protocol violation, still defined).
  - D grant with d_write=0: mem_read=1, mem_write=0.
- Latency: a request seen in IDLE at cycle N drives the mem strobe from cycle N+1.
- Latched fields stay constant through SERVE_x regardless of requester input changes or a requester dropping its request.
- Completion in SERVE_x:
  - Owner resp = mem_resp, combinational, in the same cycle. The other resp stays 0.
  - i_rdata and d_rdata are combinational pass-throughs of mem_rdata; valid only when the matching resp is 1.
  - On the mem_resp edge: state=IDLE, mem_read=0, mem_write=0. Address, data and byte-enable fields hold their values.
  - At least one IDLE cycle always separates transactions. A requester holding its request through its resp cycle is not re-granted on that cycle.
- mem_resp while in IDLE: ignored, no resp pulse.
- Reset mid-transaction: strobes drop immediately and no resp pulse is produced. A late mem_resp after reset is ignored.
- Never drive mem_read and mem_write both 1.

Test Plan:
- I read only: i_read=1, i_address=0x60; mem_resp on cycle 4 with mem_rdata=0x00000013.
  - From cycle 1: mem_read=1, mem_address=0x60, mem_byte_enable=0xF.
  - Cycle 4: i_resp=1 with i_rdata=0x13, d_resp=0.
  - Cycle 5: mem_read=0.
- D write: d_write=1, d_address=0x100, d_wdata=0xDEADBEEF, d_byte_enable=0x3.
  - mem_write=1 with those fields, mem_read=0.
  - d_resp pulses on mem_resp; i_resp stays 0.
- Simultaneous: i_read and d_read both asserted in cycle 0 with streak=0.
  - D is served first (d_address on mem_address).
  - After d_resp and one IDLE cycle, I is served.
- Starvation, MAX_D_STREAK=4: i_read held, D re-requests immediately after every d_resp.
  - Grant order is D,D,D,D,I,D…
  - streak reads 1,2,3,4 then returns to 0 after the I grant.
- Stability: during SERVE_D, change d_address to 0x200 and drop d_write.
  - mem_address stays 0x100 and mem_write stays 1 until mem_resp; d_resp still pulses.
- Reset mid-op: rst=0 while mem_read=1.
  - All mem_* outputs are 0 in the same cycle.
  - After release, mem_resp=1 in IDLE gives i_resp=d_resp=0 and the state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction fetcher and a data port.
// Data wins arbitration; a streak counter keeps fetch from starving.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  state_t                state;
  state_t                state_n;
  logic [SW-1:0]         streak;
  logic [SW-1:0]         streak_n;
  logic                  rd_n;
  logic                  wr_n;
  logic [BW-1:0]         be_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic                  dreq;
  logic                  grant_d;
  logic                  grant_i;

  assign dreq    = d_read | d_write;
  assign grant_d = dreq & (~i_read | (streak < SMAX));
  assign grant_i = ~grant_d & i_read;

  assign i_resp  = (state == SERVE_I) & mem_resp;
  assign d_resp  = (state == SERVE_D) & mem_resp;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // State, streak and the latched memory command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      streak          <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= '0;
      mem_address     <= '0;
      mem_wdata       <= '0;
    end else begin
      state           <= state_n;
      streak          <= streak_n;
      mem_read        <= rd_n;
      mem_write       <= wr_n;
      mem_byte_enable <= be_n;
      mem_address     <= addr_n;
      mem_wdata       <= wdata_n;
    end
  end

  // Arbitrate in IDLE, hold the command while serving, release on resp
  always_comb begin
    state_n  = state;
    streak_n = streak;
    rd_n     = mem_read;
    wr_n     = mem_write;
    be_n     = mem_byte_enable;
    addr_n   = mem_address;
    wdata_n  = mem_wdata;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          grant_d: begin
            state_n = SERVE_D;
            if (!i_read) streak_n = '0;
            else if (streak != SMAX) streak_n = streak + 1'b1;
            wr_n    = d_write;
            rd_n    = ~d_write;
            be_n    = d_byte_enable;
            addr_n  = d_address;
            wdata_n = d_wdata;
          end
          grant_i: begin
            state_n  = SERVE_I;
            streak_n = '0;
            rd_n     = 1'b1;
            wr_n     = 1'b0;
            be_n     = '1;
            addr_n   = i_address;
            wdata_n  = '0;
          end
          default: ;
        endcase
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_n = IDLE;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small memory model.
// Requester tasks push expectations; a monitor checks every resp pulse.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_D_STREAK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_read(i_read),
    .i_address(i_address),
    .i_rdata(i_rdata),
    .i_resp(i_resp),
    .d_read(d_read),
    .d_write(d_write),
    .d_byte_enable(d_byte_enable),
    .d_address(d_address),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_resp(d_resp),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_address(mem_address),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_resp(mem_resp)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } txn_t;

  txn_t i_q[$];
  txn_t d_q[$];
  byte  grant_log[$];
  txn_t e;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] wv;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 32'h5A5A0000 | a;
  endfunction

  logic auto_resp = 1'b0;
  logic man_resp  = 1'b0;
  logic rsp_en    = 1'b1;
  int   lat       = 1;
  int   wcnt      = 0;

  assign mem_resp = rsp_en ? auto_resp : man_resp;

  // Memory responder: answers a strobe after lat idle cycles
  initial begin
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_resp || !rsp_en) begin
        auto_resp = 1'b0;
        wcnt = 0;
      end else if (mem_read || mem_write) begin
        if (wcnt >= lat) begin
          if (mem_write) begin
            wv = rd_mem(mem_address);
            for (int b = 0; b < 4; b++)
              if (mem_byte_enable[b])
                wv[8*b +: 8] = mem_wdata[8*b +: 8];
            mem_model[mem_address] = wv;
            mem_rdata = 32'hBAD0BAD0;
          end else begin
            mem_rdata = rd_mem(mem_address);
          end
          auto_resp = 1'b1;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Monitor: pop and check the owner's expectation on each resp
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        chk("rd_wr_excl", 32'(mem_read & mem_write), 0);
        if (i_resp && d_resp)
          chk("both_resp", 1, 0);
        if (i_resp) begin
          if (i_q.size() == 0) begin
            chk("spurious_i_resp", 1, 0);
          end else begin
            e = i_q.pop_front();
            grant_log.push_back("I");
            chk("i_mem_read", 32'(mem_read), 1);
            chk("i_mem_write", 32'(mem_write), 0);
            chk("i_addr", mem_address, e.addr);
            chk("i_be", 32'(mem_byte_enable), 32'hF);
            chk("i_wdata", mem_wdata, 0);
            chk("i_rdata", i_rdata, e.rdata);
          end
        end
        if (d_resp) begin
          if (d_q.size() == 0) begin
            chk("spurious_d_resp", 1, 0);
          end else begin
            e = d_q.pop_front();
            grant_log.push_back("D");
            chk("d_mem_write", 32'(mem_write), 32'(e.wr));
            chk("d_mem_read", 32'(mem_read), 32'(!e.wr));
            chk("d_addr", mem_address, e.addr);
            chk("d_be", 32'(mem_byte_enable), 32'(e.be));
            chk("d_wdata", mem_wdata, e.wdata);
            if (!e.wr) chk("d_rdata", d_rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic wait_resp(input bit is_i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_i ? i_resp : d_resp) && n < 200);
    if (n >= 200) chk(is_i ? "i_timeout" : "d_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic i_req(input logic [31:0] a, input logic [31:0] exp);
    txn_t t;
    t.wr = 1'b0; t.addr = a; t.wdata = 0; t.be = 4'hF; t.rdata = exp;
    i_q.push_back(t);
    i_read = 1'b1;
    i_address = a;
    wait_resp(1'b1);
  endtask

  task automatic d_req(input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.be = be; t.rdata = exp;
    d_q.push_back(t);
    d_read = !wr;
    d_write = wr;
    d_address = a;
    d_wdata = wd;
    d_byte_enable = be;
    wait_resp(1'b0);
  endtask

  task automatic i_idle();
    i_read = 1'b0;
  endtask

  task automatic d_idle();
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic chk_log(input string exp);
    chk("grant_count", grant_log.size(), exp.len());
    for (int k = 0; k < exp.len() && k < grant_log.size(); k++)
      chk($sformatf("grant_%0d", k), 32'(grant_log[k]), 32'(exp[k]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    i_read = 0; i_address = 0;
    d_read = 0; d_write = 0; d_byte_enable = 0;
    d_address = 0; d_wdata = 0;
    mem_model[32'h60] = 32'h00000013;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_be", 32'(mem_byte_enable), 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_i_resp", 32'(i_resp), 0);
    chk("rst_d_resp", 32'(d_resp), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    lat = 3;
    fork
      i_req(32'h60, 32'h13);
      begin
        @(negedge clk);
        chk("lat_c0_rd", 32'(mem_read), 0);
        @(negedge clk);
        chk("lat_c1_rd", 32'(mem_read), 1);
        chk("lat_c1_addr", mem_address, 32'h60);
        chk("lat_c1_be", 32'(mem_byte_enable), 32'hF);
        repeat (2) @(negedge clk);
        chk("lat_c3_iresp", 32'(i_resp), 0);
        @(negedge clk);
        chk("lat_c4_iresp", 32'(i_resp), 1);
        chk("lat_c4_dresp", 32'(d_resp), 0);
      end
    join
    i_idle();
    chk("i_done_rd", 32'(mem_read), 0);
    lat = 1;

    d_req(1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 0);
    d_idle();
    chk("d_done_wr", 32'(mem_write), 0);
    d_req(1'b0, 32'h100, 0, 4'hF, 32'h5A5ABEEF);
    d_idle();
    @(posedge clk); #1;

    grant_log.delete();
    fork
      begin i_req(32'h60, 32'h13); i_idle(); end
      begin d_req(1'b0, 32'h104, 0, 4'hF, 32'h5A5A0104); d_idle(); end
    join
    chk_log("DI");
    @(posedge clk); #1;

    grant_log.delete();
    fork
      begin i_req(32'h64, 32'h5A5A0064); i_idle(); end
      begin
        d_req(1'b0, 32'h80, 0, 4'hF, 32'h5A5A0080);
        d_req(1'b0, 32'h84, 0, 4'hF, 32'h5A5A0084);
        d_req(1'b0, 32'h88, 0, 4'hF, 32'h5A5A0088);
        d_req(1'b0, 32'h8C, 0, 4'hF, 32'h5A5A008C);
        d_req(1'b0, 32'h90, 0, 4'hF, 32'h5A5A0090);
        d_idle();
      end
    join
    chk_log("DDDDID");
    @(posedge clk); #1;

    lat = 3;
    fork
      begin
        d_req(1'b1, 32'h100, 32'h11223344, 4'hF, 0);
        d_idle();
      end
      begin
        @(posedge clk); #2;
        d_address = 32'h200;
        d_write = 1'b0;
        @(negedge clk);
        chk("hold_addr", mem_address, 32'h100);
        chk("hold_wr", 32'(mem_write), 1);
      end
    join
    lat = 1;
    d_req(1'b0, 32'h100, 0, 4'hF, 32'h11223344);
    d_idle();
    @(posedge clk); #1;

    rsp_en = 1'b0;
    i_read = 1'b1;
    i_address = 32'h40;
    @(posedge clk); #1;
    chk("mid_rd", 32'(mem_read), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(mem_read), 0);
    chk("mid_rst_wr", 32'(mem_write), 0);
    chk("mid_rst_addr", mem_address, 0);
    chk("mid_rst_be", 32'(mem_byte_enable), 0);
    chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_iresp", 32'(i_resp), 0);
    i_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    man_resp = 1'b1;
    @(negedge clk);
    chk("late_iresp", 32'(i_resp), 0);
    chk("late_dresp", 32'(d_resp), 0);
    @(posedge clk); #1;
    man_resp = 1'b0;
    @(negedge clk);
    chk("late_idle_rd", 32'(mem_read), 0);
    chk("late_idle_wr", 32'(mem_write), 0);
    rsp_en = 1'b1;
    @(posedge clk); #1;

    i_req(32'h60, 32'h13);
    i_idle();
    @(posedge clk); #1;

    chk("i_q_empty", i_q.size(), 0);
    chk("d_q_empty", d_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
